fir_decim_requant: RTL

- Sits directly downstream of the FIR filter and consumes its 32-bit signed accumulator output.
- Keeps one sample in every DECIM, then requantizes it to OUT_W bits: round half up, arithmetic right shift, saturate.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the next stage.
- Reports saturation and dropped samples with sticky flags.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_decim_requant_if.sv | 7 +
 rtl/fir_sample_fifo.sv | 50 +++++
 rtl/fir_decim_requant.sv | 70 +++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: widths, sample types and saturation helper shared across the FIR chain
package fir_pkg;
  localparam int FIR_IN_W = 32;
  localparam int FIR_OUT_W = 16;
  typedef logic signed [FIR_IN_W-1:0] sample_in_t;
  typedef logic signed [FIR_OUT_W-1:0] sample_out_t;
  function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/fir_decim_requant_if.sv
// fir_decim_requant_if: valid/ready sample stream
interface fir_decim_requant_if #(parameter int W = 16) ();
  logic valid, ready;
  logic signed [W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: first-word-fall-through FIFO; output holds last head when empty
module fir_sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic [W-1:0] last_q, last_d;
  logic do_push, do_pop;
  assign empty = lvl_q == '0;
  assign full = lvl_q == (AW+1)'(DEPTH);
  assign level = lvl_q;
  assign dout = empty ? last_q : mem_q[rd_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    lvl_d = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    last_d = dout;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      last_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      last_q <= last_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fir_decim_requant.sv
// fir_decim_requant: keep 1 of DECIM samples, round/shift/saturate, buffer in a FIFO
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int IN_W = FIR_IN_W,
  parameter int OUT_W = FIR_OUT_W,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_decim_requant_if.slave     in_s,
  fir_decim_requant_if.master    out_m,
  input  logic                   flag_clear,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sat_flag,
  output logic                   drop_flag
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam logic signed [IN_W:0] RND = (IN_W+1)'((2 ** SHIFT) / 2);
  logic [PW-1:0] phase_q, phase_d;
  logic v1_q, v1_d, sat_q, sat_d, drop_q, drop_d;
  logic signed [IN_W:0] r_q, r_d;
  logic signed [63:0] sat_w;
  logic [OUT_W-1:0] q_val, dout;
  logic clipped, full, empty, pop;
  assign in_s.ready = 1'b1;
  assign out_m.valid = !empty;
  assign out_m.data = dout;
  assign sat_flag = sat_q;
  assign drop_flag = drop_q;
  always_comb begin
    phase_d = in_s.valid ? (phase_q == PW'(DECIM - 1) ? '0 : phase_q + 1'b1) : phase_q;
    v1_d = in_s.valid && phase_q == '0;
    r_d = ($signed({in_s.data[IN_W-1], in_s.data}) + RND) >>> SHIFT;
    sat_w = sat_to_out(64'(r_q), OUT_W);
    clipped = sat_w != 64'(r_q);
    q_val = OUT_W'(sat_w);
    pop = out_m.valid && out_m.ready;
    sat_d = (v1_q && clipped) || (sat_q && !flag_clear);
    drop_d = (v1_q && full && !pop) || (drop_q && !flag_clear);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      v1_q <= 1'b0;
      r_q <= '0;
      sat_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      v1_q <= v1_d;
      r_q <= r_d;
      sat_q <= sat_d;
      drop_q <= drop_d;
    end
  end
  fir_sample_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(v1_q),
    .pop(pop),
    .din(q_val),
    .dout(dout),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
endmodule
